m_alu_unary_issue: RTL and testbench

Operand issue buffer directly upstream of `m_alu_unary`. Accepts unary-ALU requests (operation, 32-bit operand, tag) from decode over a valid/ready handshake, holds them in a DEPTH-entry first-word-fall-through FIFO, and presents the oldest entry to the unary ALU and its consumer via a second valid/ready handshake. Decouples decode from execute stalls and supports a single-cycle pipeline flush.

---
 rtl/m_alu_unary_issue_pkg.sv | 24 ++
 rtl/m_alu_unary_issue.sv | 101 ++++++++++
 tb/tb_m_alu_unary_issue.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/m_alu_unary_issue_pkg.sv
// Shared unary-ALU types: operation encoding, request bundle and default tag width.
package p_alu;

  // Default width of the tag travelling with each unary request.
  localparam int ALU_TAG_W = 4;

  // Operations understood by the unary ALU; ID passes the operand through.
  typedef enum logic [2:0] {
    UNARY_OP_ID   = 3'd0,
    UNARY_OP_NEG  = 3'd1,
    UNARY_OP_NOT  = 3'd2,
    UNARY_OP_ZERO = 3'd3,
    UNARY_OP_INC  = 3'd4,
    UNARY_OP_DEC  = 3'd5
  } e_unary_op;

  // One request as it moves from decode through the issue buffer to the ALU.
  typedef struct packed {
    e_unary_op            op;
    logic [31:0]          in;
    logic [ALU_TAG_W-1:0] tag;
  } s_unary_req;

endpackage

// File: rtl/m_alu_unary_issue.sv
// Issue buffer in front of the unary ALU: a small first-word-fall-through FIFO
// that decouples decode from execute stalls and supports a one-cycle flush.
module m_alu_unary_issue
  import p_alu::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  e_unary_op                req_op,
  input  logic [31:0]              req_in,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output e_unary_op                iss_op,
  output logic [31:0]              iss_in,
  output logic [TAG_W-1:0]         iss_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Entry layout follows the TAG_W parameter so non-default tag widths work.
  typedef struct packed {
    e_unary_op          op;
    logic [31:0]        in;
    logic [TAG_W-1:0]   tag;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push;
  logic               pop;

  // Handshakes depend only on registered occupancy, so no input reaches an output.
  assign req_ready = (count_q != FULL_COUNT);
  assign iss_valid = (count_q != '0);
  assign push      = req_valid && req_ready;
  assign pop       = iss_valid && iss_ready;
  assign count     = count_q;

  // Next-state for pointers and occupancy; flush collapses the buffer and ignores traffic.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      rdPtr_d = wrPtr_q;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers; reset outranks flush and drops every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array is never cleared; only accepted, non-flushed pushes write it.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_q[wrPtr_q] <= '{op: req_op, in: req_in, tag: req_tag};
    end
  end

  // Head read mux; an empty buffer presents a harmless pass-through of zero.
  always_comb begin
    iss_op  = UNARY_OP_ID;
    iss_in  = '0;
    iss_tag = '0;
    if (iss_valid) begin
      iss_op  = mem_q[rdPtr_q].op;
      iss_in  = mem_q[rdPtr_q].in;
      iss_tag = mem_q[rdPtr_q].tag;
    end
  end

endmodule

// File: tb/tb_m_alu_unary_issue.sv
// Bench for the unary issue buffer: directed scenarios then random traffic,
// every cycle compared against a queue-based reference of the buffer.
module tb_m_alu_unary_issue;
  import p_alu::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  e_unary_op         req_op;
  logic [31:0]       req_in;
  logic [TAG_W-1:0]  req_tag;
  logic              iss_valid;
  logic              iss_ready;
  e_unary_op         iss_op;
  logic [31:0]       iss_in;
  logic [TAG_W-1:0]  iss_tag;
  logic [2:0]        count;

  int numVectors = 0;
  int numMiscompares = 0;

  typedef struct {
    e_unary_op        op;
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
  } entry_t;

  entry_t model[$];

  m_alu_unary_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_in    (req_in),
    .req_tag   (req_tag),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_op    (iss_op),
    .iss_in    (iss_in),
    .iss_tag   (iss_tag),
    .count     (count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numVectors++;
    if (observed !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compares all DUT outputs against the reference queue.
  task automatic compareAll();
    int sz;
    sz = model.size();
    checkOutput("count", 64'(count), 64'(sz));
    checkOutput("req_ready", 64'(req_ready), 64'(sz != DEPTH));
    checkOutput("iss_valid", 64'(iss_valid), 64'(sz != 0));
    if (sz != 0) begin
      checkOutput("iss_op", 64'(iss_op), 64'(model[0].op));
      checkOutput("iss_in", 64'(iss_in), 64'(model[0].d));
      checkOutput("iss_tag", 64'(iss_tag), 64'(model[0].t));
    end else begin
      checkOutput("iss_op_empty", 64'(iss_op), 64'(UNARY_OP_ID));
      checkOutput("iss_in_empty", 64'(iss_in), 64'd0);
      checkOutput("iss_tag_empty", 64'(iss_tag), 64'd0);
    end
  endtask

  // Drives one cycle of inputs, advances the reference at the edge, then checks.
  task automatic applyStimulus(input bit rv, input e_unary_op op, input logic [31:0] d,
                               input logic [TAG_W-1:0] t, input bit ir, input bit fl, input bit rs);
    bit canPush;
    bit canPop;
    entry_t e;
    req_valid = rv;
    req_op    = op;
    req_in    = d;
    req_tag   = t;
    iss_ready = ir;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    if (rs || fl) begin
      model.delete();
    end else begin
      canPush = (model.size() < DEPTH);
      canPop  = (model.size() > 0);
      if (ir && canPop) void'(model.pop_front());
      if (rv && canPush) begin
        e.op = op;
        e.d  = d;
        e.t  = t;
        model.push_back(e);
      end
    end
    #1;
    compareAll();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; iss_ready = 1'b0;
    req_op = UNARY_OP_ID; req_in = '0; req_tag = '0;

    // Reset state.
    applyStimulus(0, UNARY_OP_ID, 0, 0, 0, 0, 1);
    applyStimulus(0, UNARY_OP_ID, 0, 0, 0, 0, 1);

    // First push is visible the next cycle.
    applyStimulus(1, UNARY_OP_NEG, 32'h1, 4'd3, 0, 0, 0);
    checkOutput("first_push_op", 64'(iss_op), 64'(UNARY_OP_NEG));
    checkOutput("first_push_tag", 64'(iss_tag), 64'd3);
    applyStimulus(0, UNARY_OP_ID, 0, 0, 1, 0, 0);

    // Fill to DEPTH, attempt a fifth push, then drain in order.
    for (int i = 0; i < 5; i++)
      applyStimulus(1, UNARY_OP_INC, 32'h100 + 32'(i), 4'(i), 0, 0, 0);
    checkOutput("full_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_tag", 64'(iss_tag), 64'(i));
      applyStimulus(0, UNARY_OP_ID, 0, 0, 1, 0, 0);
    end

    // Sustained push+pop at occupancy 2 with wrapping pointers.
    applyStimulus(1, UNARY_OP_NOT, 32'haaaaaaaa, 4'd0, 0, 0, 0);
    applyStimulus(1, UNARY_OP_NOT, 32'h55555555, 4'd1, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, UNARY_OP_NOT, (i % 2 == 0) ? 32'haaaaaaaa : 32'h55555555, 4'(i + 2), 1, 0, 0);
    checkOutput("steady_count", 64'(count), 64'd2);

    // Flush at occupancy 3 together with a request.
    applyStimulus(1, UNARY_OP_DEC, 32'h77, 4'd9, 0, 0, 0);
    applyStimulus(1, UNARY_OP_DEC, 32'h88, 4'd10, 1, 1, 0);
    checkOutput("flush_count", 64'(count), 64'd0);

    // Reset while full, then a fresh push.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, UNARY_OP_NEG, 32'(i), 4'(i), 0, 0, 0);
    applyStimulus(0, UNARY_OP_ID, 0, 0, 0, 0, 1);
    checkOutput("rst_ready", 64'(req_ready), 64'd1);
    applyStimulus(1, UNARY_OP_ZERO, 32'hffffffff, 4'd5, 0, 0, 0);
    applyStimulus(0, UNARY_OP_ID, 0, 0, 1, 0, 0);

    // Empty buffer with iss_ready high: push is not popped in the same cycle.
    applyStimulus(1, UNARY_OP_ID, 32'h1234, 4'd6, 1, 0, 0);
    checkOutput("no_bypass_count", 64'(count), 64'd1);
    applyStimulus(0, UNARY_OP_ID, 0, 0, 1, 0, 0);
    checkOutput("no_bypass_drained", 64'(count), 64'd0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 3) != 0, e_unary_op'($urandom_range(0, 5)), $urandom,
                    4'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
